// File: rtl/seven_segment_scan_driver_pkg.sv
// Glyph constants for the 7-segment scan driver, active-low {a,b,c,d,e,f,g}.
// No latency or backpressure; constants only.
package seven_segment_scan_driver_pkg;
  localparam logic [6:0] SSD_0     = 7'b0000001;
  localparam logic [6:0] SSD_1     = 7'b1001111;
  localparam logic [6:0] SSD_2     = 7'b0010010;
  localparam logic [6:0] SSD_3     = 7'b0000110;
  localparam logic [6:0] SSD_4     = 7'b1001100;
  localparam logic [6:0] SSD_5     = 7'b0100100;
  localparam logic [6:0] SSD_6     = 7'b0100000;
  localparam logic [6:0] SSD_7     = 7'b0001111;
  localparam logic [6:0] SSD_8     = 7'b0000000;
  localparam logic [6:0] SSD_9     = 7'b0000100;
  localparam logic [6:0] SSD_A     = 7'b0001000;
  localparam logic [6:0] SSD_B     = 7'b1100000;
  localparam logic [6:0] SSD_C     = 7'b0110001;
  localparam logic [6:0] SSD_D     = 7'b1000010;
  localparam logic [6:0] SSD_E     = 7'b0110000;
  localparam logic [6:0] SSD_F     = 7'b0111000;
  localparam logic [6:0] SSD_BLANK = 7'b1111111;
  localparam logic [7:0] DISP_OFF  = 8'hFF;
endpackage

// File: rtl/seven_segment_scan_driver_glyph_rom.sv
// Combinational nibble-to-segment decode (active-low); zero latency, no backpressure.
// HEX_MODE=0 maps nibbles 10..15 to the F error glyph.
module seven_segment_scan_driver_glyph_rom
  import seven_segment_scan_driver_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SSD_F;
    case (nibble_i)
      4'd0:  seg_o = SSD_0;
      4'd1:  seg_o = SSD_1;
      4'd2:  seg_o = SSD_2;
      4'd3:  seg_o = SSD_3;
      4'd4:  seg_o = SSD_4;
      4'd5:  seg_o = SSD_5;
      4'd6:  seg_o = SSD_6;
      4'd7:  seg_o = SSD_7;
      4'd8:  seg_o = SSD_8;
      4'd9:  seg_o = SSD_9;
      4'd10: seg_o = (HEX_MODE != 0) ? SSD_A : SSD_F;
      4'd11: seg_o = (HEX_MODE != 0) ? SSD_B : SSD_F;
      4'd12: seg_o = (HEX_MODE != 0) ? SSD_C : SSD_F;
      4'd13: seg_o = (HEX_MODE != 0) ? SSD_D : SSD_F;
      4'd14: seg_o = (HEX_MODE != 0) ? SSD_E : SSD_F;
      default: seg_o = SSD_F;
    endcase
  end
endmodule

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit common-anode driver; outputs registered 1 cycle after idx/shadow.
// No backpressure: en=0 freezes the scan and blanks pins. Option: LEADING_ZERO_BLANK_EN.
module seven_segment_scan_driver
  import seven_segment_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1,
  parameter int DIV_WIDTH   = 16,
  parameter int HEX_MODE    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dots_in,
  output logic [7:0]              display,
  output logic [NUM_DIGITS-1:0]   ctrl,
  output logic                    frame_tick
);
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dots_q, dots_d;
  logic [7:0]              display_q, display_d;
  logic [NUM_DIGITS-1:0]   ctrl_q, ctrl_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [3:0]            cur_nib;
  logic                  cur_dot;
  logic                  cur_blank;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  slot_end;

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i>0 blanks only when it and every higher nibble are zero.
  logic run_zero;
  always_comb begin
    lz_blank = '0;
    run_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run_zero    = run_zero & (digits_q[4*i +: 4] == 4'd0);
      lz_blank[i] = run_zero;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    cur_nib   = '0;
    cur_dot   = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = digits_q[4*i +: 4];
        cur_dot   = dots_q[i];
        cur_blank = lz_blank[i];
      end
    end
  end

  seven_segment_scan_driver_glyph_rom #(.HEX_MODE(HEX_MODE)) u_glyph (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

  assign slot_end = (presc_q == DIV_LAST);

  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    digits_d = digits_q;
    dots_d   = dots_q;
    if (en) begin
      if (slot_end) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (load) begin
      digits_d = digits_in;
      dots_d   = dots_in;
    end
    display_d    = en ? {(cur_blank ? SSD_BLANK : cur_seg), ~cur_dot} : DISP_OFF;
    ctrl_d       = en ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    frame_tick_d = en && slot_end && (idx_q == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      digits_q     <= '0;
      dots_q       <= '0;
      display_q    <= DISP_OFF;
      ctrl_q       <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      digits_q     <= digits_d;
      dots_q       <= dots_d;
      display_q    <= display_d;
      ctrl_q       <= ctrl_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign display    = display_q;
  assign ctrl       = ctrl_q;
  assign frame_tick = frame_tick_q;
endmodule
